register_read_stage: RTL
========================

Name: register_read_stage

Overview:
- Pipeline stage directly upstream of the execute stage; owns the 16-entry architectural register file.
- Takes decoded instructions and reads rs/rt, applying operand forwarding from execute (in-flight result) and from the writeback port.
- Presents a registered instruction bundle (rr_*) to execute, honouring execute stall and flush.

Parameters:
- NUM_REGS, 16, number of architectural registers; index width is fixed at 4 bits.
- R0_ZERO, 1, when 1: register 0 reads as 0, writes to it are dropped, and it is never a forwarding source.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  asynchronous active-high reset
- dec_valid  in  1  decode bundle valid
- dec_pc  in  32  instruction PC
- dec_op  in  6  primary opcode
- dec_altop  in  8  extended opcode
- dec_rd  in  4  destination register
- dec_rs  in  4  source register 1
- dec_rt  in  4  source register 2
- dec_imm32  in  32  sign-extended immediate
- exec_stall  in  1  execute cannot accept a new instruction
- exec_flush  in  1  taken branch/jump in execute; squash the younger instruction
- exec_of_reg  in  4  execute forwarding destination (combinational, equals the current rr_rd)
- exec_of_val  in  32  execute forwarding value
- exec_rd  in  4  writeback destination; 0 means no write
- exec_rd_val  in  32  writeback data
- rr_stall  out  1  hold decode
- rr_pc  out  32  registered PC to execute
- rr_op  out  6  registered op
- rr_altop  out  8  registered altop
- rr_rd  out  4  registered destination
- rr_rs_val  out  32  registered rs operand
- rr_rt_val  out  32  registered rt operand
- rr_imm32  out  32  registered immediate

Behaviour:
- Reset (async, i_reset=1): all rr_* outputs 0 (bubble); all registers 0. Reset mid-operation discards the in-flight bundle and any pending write.
- Register file:
  - Write on posedge when exec_rd != 0 (and, with R0_ZERO=1, exec_rd is not 0).
  - Write occurs even while exec_stall=1, because writeback comes from the already-registered exec_rd.
- Operand resolution (combinational, per source s in {rs, rt}), highest priority first:
  - s==0 with R0_ZERO=1 -> 0.
  - s==exec_of_reg and exec_of_reg!=0 -> exec_of_val.
  - s==exec_rd and exec_rd!=0 -> exec_rd_val (same-cycle write bypass).
  - Otherwise -> regfile[s].
- Bubble: op=0, altop=0, rd=0, pc=0, rs_val=rt_val=imm32=0. Execute counts neither retired instructions nor writes for a bubble.
- Pipeline register update on posedge, priority order:
  1. exec_stall=1: all rr_* hold. Operand resolution for the waiting decode bundle is recomputed every cycle.
  2. Else if exec_flush=1: load a bubble regardless of dec_valid.
  3. Else if dec_valid=0: load a bubble.
  4. Else: load the decode bundle with the resolved operands.
- Simultaneous stall and flush: stall wins. The branch stays in rr and re-asserts flush when the stall releases.
- rr_stall = exec_stall (combinational). A flush never stalls decode.
- Latency: 1 cycle decode->rr. A back-to-back dependency incurs no stall because the exec_of path covers it.

Test Plan:
- Reset -> all rr_* = 0. Write r3=0x1234 via exec_rd, then decode rs=3 -> rr_rs_val=0x1234 one cycle later.
- Forwarding priority: regfile r5=1, exec_rd=5/val=2, exec_of_reg=5/val=3 at the same time; decode rs=5,rt=5 -> rr_rs_val=rr_rt_val=3. Drop exec_of -> 2.
- R0: exec_rd=0 with val 0xFFFF, exec_of_reg=0; decode rs=0 -> rr_rs_val=0 and r0 remains 0.
- Stall: exec_stall high for 3 cycles with rr_pc=0x40 -> rr_* hold for 3 cycles and rr_stall=1. A writeback to r7 during the stall is visible in the next bundle read of r7.
- Flush: exec_flush=1 with dec_pc=0x44 valid -> next rr is a bubble (op=0, altop=0, rd=0). With exec_stall=1 as well -> rr holds, then bubbles after the stall releases.
- Async reset asserted mid-cycle while rr holds a valid ADDI -> rr_* go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/register_read_stage.sv
// Register-read stage: owns the architectural register file, resolves the rs/rt
// operands with forwarding from execute and writeback, and presents a registered
// instruction bundle to execute under execute's stall/flush control.
module register_read_stage #(
  parameter int unsigned NUM_REGS = 16,
  parameter bit          R0_ZERO  = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  // Decode bundle
  input  logic        dec_valid,
  input  logic [31:0] dec_pc,
  input  logic [5:0]  dec_op,
  input  logic [7:0]  dec_altop,
  input  logic [3:0]  dec_rd,
  input  logic [3:0]  dec_rs,
  input  logic [3:0]  dec_rt,
  input  logic [31:0] dec_imm32,
  // Execute control and forwarding
  input  logic        exec_stall,
  input  logic        exec_flush,
  input  logic [3:0]  exec_of_reg,
  input  logic [31:0] exec_of_val,
  input  logic [3:0]  exec_rd,
  input  logic [31:0] exec_rd_val,
  // Bundle to execute
  output logic        rr_stall,
  output logic [31:0] rr_pc,
  output logic [5:0]  rr_op,
  output logic [7:0]  rr_altop,
  output logic [3:0]  rr_rd,
  output logic [31:0] rr_rs_val,
  output logic [31:0] rr_rt_val,
  output logic [31:0] rr_imm32
);

  // Storage for the full 4-bit index space; entries at or above NUM_REGS are
  // never written and read back as zero.
  localparam int unsigned IdxSpace = 16;

  logic [31:0] regs_q [IdxSpace];

  logic [31:0] rf_rs_val;
  logic [31:0] rf_rt_val;
  logic [31:0] rs_val_res;
  logic [31:0] rt_val_res;
  logic        wb_en;

  logic [31:0] pc_q,     pc_d;
  logic [5:0]  op_q,     op_d;
  logic [7:0]  altop_q,  altop_d;
  logic [3:0]  rd_q,     rd_d;
  logic [31:0] rs_val_q, rs_val_d;
  logic [31:0] rt_val_q, rt_val_d;
  logic [31:0] imm32_q,  imm32_d;

  // Operand resolution, highest priority first: hard-wired zero, in-flight
  // execute result, same-cycle writeback, then the register file.
  function automatic logic [31:0] resolve(
    input logic [3:0]  src,
    input logic [31:0] rf_val,
    input logic [3:0]  of_reg,
    input logic [31:0] of_val,
    input logic [3:0]  wb_reg,
    input logic [31:0] wb_val
  );
    logic [31:0] res;
    if (R0_ZERO && (src == 4'd0)) begin
      res = 32'd0;
    end else if ((src == of_reg) && (of_reg != 4'd0)) begin
      res = of_val;
    end else if ((src == wb_reg) && (wb_reg != 4'd0)) begin
      res = wb_val;
    end else begin
      res = rf_val;
    end
    return res;
  endfunction

  // Writeback is accepted regardless of stall since it comes from execute's
  // already-registered destination; a zero destination means no write.
  assign wb_en = (exec_rd != 4'd0) && (int'(exec_rd) < int'(NUM_REGS));

  // Raw register file reads for both sources.
  always_comb begin
    rf_rs_val = 32'd0;
    rf_rt_val = 32'd0;
    if (int'(dec_rs) < int'(NUM_REGS)) rf_rs_val = regs_q[dec_rs];
    if (int'(dec_rt) < int'(NUM_REGS)) rf_rt_val = regs_q[dec_rt];
  end

  // Forwarded operands, recomputed every cycle even while stalled.
  always_comb begin
    rs_val_res = resolve(dec_rs, rf_rs_val, exec_of_reg, exec_of_val, exec_rd, exec_rd_val);
    rt_val_res = resolve(dec_rt, rf_rt_val, exec_of_reg, exec_of_val, exec_rd, exec_rd_val);
  end

  // Register file state; reset clears every entry and drops any pending write.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < int'(IdxSpace); i++) begin
        regs_q[i] <= 32'd0;
      end
    end else if (wb_en) begin
      regs_q[exec_rd] <= exec_rd_val;
    end
  end

  // Next bundle: stall holds (and beats flush), flush or invalid decode loads
  // a bubble, otherwise the decode bundle with resolved operands.
  always_comb begin
    pc_d     = pc_q;
    op_d     = op_q;
    altop_d  = altop_q;
    rd_d     = rd_q;
    rs_val_d = rs_val_q;
    rt_val_d = rt_val_q;
    imm32_d  = imm32_q;
    if (!exec_stall) begin
      if (exec_flush || !dec_valid) begin
        pc_d     = 32'd0;
        op_d     = 6'd0;
        altop_d  = 8'd0;
        rd_d     = 4'd0;
        rs_val_d = 32'd0;
        rt_val_d = 32'd0;
        imm32_d  = 32'd0;
      end else begin
        pc_d     = dec_pc;
        op_d     = dec_op;
        altop_d  = dec_altop;
        rd_d     = dec_rd;
        rs_val_d = rs_val_res;
        rt_val_d = rt_val_res;
        imm32_d  = dec_imm32;
      end
    end
  end

  // Pipeline register to execute; reset forces an immediate bubble.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pc_q     <= 32'd0;
      op_q     <= 6'd0;
      altop_q  <= 8'd0;
      rd_q     <= 4'd0;
      rs_val_q <= 32'd0;
      rt_val_q <= 32'd0;
      imm32_q  <= 32'd0;
    end else begin
      pc_q     <= pc_d;
      op_q     <= op_d;
      altop_q  <= altop_d;
      rd_q     <= rd_d;
      rs_val_q <= rs_val_d;
      rt_val_q <= rt_val_d;
      imm32_q  <= imm32_d;
    end
  end

  // A flush never stalls decode; only execute's stall propagates upstream.
  assign rr_stall  = exec_stall;
  assign rr_pc     = pc_q;
  assign rr_op     = op_q;
  assign rr_altop  = altop_q;
  assign rr_rd     = rd_q;
  assign rr_rs_val = rs_val_q;
  assign rr_rt_val = rt_val_q;
  assign rr_imm32  = imm32_q;

endmodule
